// File: rtl/dmem_access_ctrl_if.sv
// Data-memory port bundle between the memory-stage access sequencer (master)
// and the data memory (slave).
interface dmem_access_ctrl_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ready, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ready, dm_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Memory-stage load/store sequencer: issues one valid/ready data-memory access,
// stalls the pipeline while it is outstanding, and returns extended load data.
module dmem_access_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_valid,
  input  logic                       is_load,
  input  logic                       mem_write,
  input  logic [2:0]                 load_type,
  input  logic [2:0]                 store_type,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic                       stall,
  dmem_access_ctrl_if.master         dm,
  output logic [31:0]                ld_data,
  output logic                       ld_valid,
  output logic                       misalign,
  output logic                       bus_err
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [2:0]    lat_ty;
  logic [1:0]    lat_off;
  logic          lat_ld;

  logic          access;
  logic [2:0]    ty;
  logic          legal_type;
  logic          aligned;
  logic          ok;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [31:0]   shifted;
  logic [31:0]   ld_ext;

  // A request with both is_load and mem_write set is treated as a load.
  always_comb begin
    access     = ex_valid & (is_load | mem_write);
    ty         = is_load ? load_type : store_type;
    legal_type = is_load ? (load_type inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                         : (store_type inside {3'b000, 3'b001, 3'b010});
    case (ty[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    ok = legal_type & aligned;

    case (ty[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {24'b0, wdata[7:0]} << {addr[1:0], 3'b000};
      end
      2'b01: begin
        be_next    = 4'b0011 << {addr[1], 1'b0};
        wdata_next = {16'b0, wdata[15:0]} << {addr[1], 4'b0000};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata;
      end
    endcase

    stall    = ((state == IDLE) & access & ok) | (state == REQ);
    misalign = (state == IDLE) & access & ~ok;
  end

  always_comb begin
    shifted = dm.dm_rdata >> {lat_off, 3'b000};
    case (lat_ty)
      3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_ext = {24'b0, shifted[7:0]};
      3'b101:  ld_ext = {16'b0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      lat_ty      <= '0;
      lat_off     <= '0;
      lat_ld      <= 1'b0;
      dm.dm_req   <= 1'b0;
      dm.dm_we    <= 1'b0;
      dm.dm_addr  <= '0;
      dm.dm_be    <= '0;
      dm.dm_wdata <= '0;
      ld_data     <= '0;
      ld_valid    <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      ld_valid <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (access && ok) begin
            state       <= REQ;
            dm.dm_req   <= 1'b1;
            dm.dm_we    <= ~is_load;
            dm.dm_addr  <= {addr[31:2], 2'b00};
            dm.dm_be    <= be_next;
            dm.dm_wdata <= is_load ? '0 : wdata_next;
            lat_ty      <= ty;
            lat_off     <= addr[1:0];
            lat_ld      <= is_load;
          end
        end
        REQ: begin
          // A ready in the final permitted cycle takes priority over the abort.
          if (dm.dm_ready) begin
            state     <= RESP;
            dm.dm_req <= 1'b0;
            if (lat_ld) begin
              ld_data  <= ld_ext;
              ld_valid <= 1'b1;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            state     <= RESP;
            dm.dm_req <= 1'b0;
            bus_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        RESP: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a load-result scoreboard and a
// bench-side memory responder.
module tb_dmem_access_ctrl;
  localparam int MAXW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, is_load, mem_write;
  logic [2:0]  load_type, store_type;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid, misalign, bus_err;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .is_load(is_load),
    .mem_write(mem_write), .load_type(load_type), .store_type(store_type),
    .addr(addr), .wdata(wdata), .stall(stall), .dm(bus),
    .ld_data(ld_data), .ld_valid(ld_valid), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  logic [31:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (t)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // delay = number of dm_ready=0 REQ cycles before ready; negative means never.
  task automatic access(input string tag, input logic ld, input logic st, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                        input int delay, input logic [3:0] ebe, input logic [31:0] ewd);
    int   nreq;
    int   stalls;
    bit   good;
    logic exp_ld;
    logic [31:0] exp_data;
    good   = (delay >= 0) && (delay < MAXW);
    nreq   = good ? delay + 1 : MAXW;
    exp_ld = ld && good;
    if (exp_ld) sb.push_back(ld_model(t, a, rw));

    ex_valid = 1'b1; is_load = ld; mem_write = st;
    load_type = t; store_type = t; addr = a; wdata = wd;
    #1;
    chk({tag, " stall_idle"}, 32'(stall), 32'd1);
    chk({tag, " misalign_idle"}, 32'(misalign), 32'd0);
    stalls = int'(stall);
    @(posedge clk); #1;
    ex_valid = 1'b0; addr = $urandom; wdata = $urandom; load_type = 3'b111; store_type = 3'b111;

    for (int i = 0; i < nreq; i++) begin
      bus.dm_ready = (i == delay);
      bus.dm_rdata = (i == delay) ? rw : $urandom;
      #1;
      stalls += int'(stall);
      chk({tag, " dm_req"}, 32'(bus.dm_req), 32'd1);
      if (i == 0 || i == nreq - 1) begin
        chk({tag, " dm_addr"}, bus.dm_addr, {a[31:2], 2'b00});
        chk({tag, " dm_be"}, 32'(bus.dm_be), 32'(ebe));
        chk({tag, " dm_we"}, 32'(bus.dm_we), 32'(!ld));
        if (!ld) chk({tag, " dm_wdata"}, bus.dm_wdata, ewd);
      end
      @(posedge clk); #1;
      bus.dm_ready = 1'b0;
    end

    // RESP: a misaligned access presented now must be ignored.
    ex_valid = 1'b1; is_load = 1'b1; mem_write = 1'b0; load_type = 3'b010; addr = 32'h3;
    #1;
    chk({tag, " stall_resp"}, 32'(stall), 32'd0);
    chk({tag, " misalign_resp"}, 32'(misalign), 32'd0);
    chk({tag, " dm_req_resp"}, 32'(bus.dm_req), 32'd0);
    chk({tag, " ld_valid"}, 32'(ld_valid), 32'(exp_ld));
    chk({tag, " bus_err"}, 32'(bus_err), 32'(!good));
    chk({tag, " stall_cycles"}, 32'(stalls), 32'(nreq + 1));
    if (exp_ld) begin
      if (sb.size() == 0) chk({tag, " sb_empty"}, 32'd0, 32'd1);
      else begin
        exp_data = sb.pop_front();
        chk({tag, " ld_data"}, ld_data, exp_data);
      end
    end
    ex_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, " ld_valid_pulse"}, 32'(ld_valid), 32'd0);
    chk({tag, " bus_err_pulse"}, 32'(bus_err), 32'd0);
  endtask

  task automatic bad(input string tag, input logic ld, input logic st, input logic [2:0] t,
                     input logic [31:0] a);
    ex_valid = 1'b1; is_load = ld; mem_write = st;
    load_type = t; store_type = t; addr = a; wdata = 32'hFFFF_FFFF;
    #1;
    chk({tag, " misalign"}, 32'(misalign), 32'd1);
    chk({tag, " stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk({tag, " dm_req"}, 32'(bus.dm_req), 32'd0);
    ex_valid = 1'b0;
    #1;
    chk({tag, " misalign_clear"}, 32'(misalign), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; is_load = 1'b0; mem_write = 1'b0;
    load_type = '0; store_type = '0; addr = '0; wdata = '0;
    bus.dm_ready = 1'b0; bus.dm_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst dm_req", 32'(bus.dm_req), 32'd0);
    chk("rst dm_we", 32'(bus.dm_we), 32'd0);
    chk("rst dm_be", 32'(bus.dm_be), 32'd0);
    chk("rst dm_addr", bus.dm_addr, 32'd0);
    chk("rst dm_wdata", bus.dm_wdata, 32'd0);
    chk("rst ld_data", ld_data, 32'd0);
    chk("rst ld_valid", 32'(ld_valid), 32'd0);
    chk("rst misalign", 32'(misalign), 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    rst = 1'b0;

    access("lw",   1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h0);
    access("lb",   1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 4'b1000, 32'h0);
    access("lbu",  1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 4'b1000, 32'h0);
    access("lh",   1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 2, 4'b1100, 32'h0);
    access("lhu",  1'b1, 1'b0, 3'b101, 32'h000, 32'h0, 32'h1234F00D, 1, 4'b0011, 32'h0);
    access("sh",   1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 4'b1100, 32'hABCD0000);
    access("sb",   1'b0, 1'b1, 3'b000, 32'h301, 32'h000000AB, 32'h0, 0, 4'b0010, 32'h0000AB00);
    access("both", 1'b1, 1'b1, 3'b010, 32'h010, 32'hFFFFFFFF, 32'h55AA55AA, 0, 4'b1111, 32'h0);

    bad("lw_mis", 1'b1, 1'b0, 3'b010, 32'h101);
    bad("sh_mis", 1'b0, 1'b1, 3'b001, 32'h203);
    bad("ld_ill", 1'b1, 1'b0, 3'b011, 32'h000);
    bad("st_ill", 1'b0, 1'b1, 3'b100, 32'h000);

    access("timeout", 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, -1, 4'b1111, 32'h0);
    access("ready16", 1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 32'hCAFEF00D, MAXW - 1, 4'b1111, 32'h0);

    // Reset during the third REQ cycle of a never-answered load.
    ex_valid = 1'b1; is_load = 1'b1; mem_write = 1'b0; load_type = 3'b010; addr = 32'h40;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    #1;
    chk("rstreq dm_req", 32'(bus.dm_req), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstreq dm_req_drop", 32'(bus.dm_req), 32'd0);
    chk("rstreq stall", 32'(stall), 32'd0);
    chk("rstreq ld_valid", 32'(ld_valid), 32'd0);
    chk("rstreq bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    chk("rstreq ld_valid_next", 32'(ld_valid), 32'd0);
    chk("rstreq bus_err_next", 32'(bus_err), 32'd0);

    access("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'h0BADF00D, 0, 4'b1111, 32'h0);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
